// File: rtl/tiny_nn_seq.sv
// Layer sequencer for the tiny NN core: walks every neuron of one fully-connected
// layer, driving accumulator clear, MAC enables, result writes and memory addresses.
module tiny_nn_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          stall_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          acc_clr_o,
  output logic                          mac_en_o,
  output logic                          out_we_o,
  output logic [$clog2(N_IN*N_OUT)-1:0] w_addr_o,
  output logic [$clog2(N_IN)-1:0]       x_addr_o,
  output logic [$clog2(N_OUT)-1:0]      out_addr_o
);

  // state   | meaning
  // IDLE    | waiting for start_i, counters at zero
  // CLEAR   | clear accumulator for neuron j
  // MAC     | accumulate input k of neuron j
  // WRITE   | write activated result of neuron j
  // DONE    | one-cycle end-of-pass pulse

  localparam int KW = $clog2(N_IN);
  localparam int JW = $clog2(N_OUT);
  localparam int WW = $clog2(N_IN*N_OUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [JW-1:0]   j_q, j_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    if (state_q == S_IDLE) begin
      if (start_i && !abort_i) state_d = S_CLEAR;
    end else if (abort_i) begin
      state_d = S_IDLE;
      k_d     = '0;
      j_d     = '0;
    end else if (!(stall_i && state_q != S_DONE)) begin
      case (state_q)
        S_CLEAR: begin
          k_d     = '0;
          state_d = S_MAC;
        end
        S_MAC: begin
          if (k_q == KW'(N_IN - 1)) state_d = S_WRITE;
          else                      k_d     = k_q + KW'(1);
        end
        S_WRITE: begin
          if (j_q == JW'(N_OUT - 1)) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + JW'(1);
            state_d = S_CLEAR;
          end
        end
        S_DONE: begin
          j_d     = '0;
          k_d     = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are gated by stall_i directly so a held cycle never double-fires.
  always_comb begin
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_DONE);
    acc_clr_o  = (state_q == S_CLEAR) && !stall_i;
    mac_en_o   = (state_q == S_MAC)   && !stall_i;
    out_we_o   = (state_q == S_WRITE) && !stall_i;
    x_addr_o   = k_q;
    out_addr_o = j_q;
    w_addr_o   = WW'(j_q) * WW'(N_IN) + WW'(k_q);
  end

endmodule

// File: tb/tb_tiny_nn_seq.sv
// Bench for tiny_nn_seq: scenario table, hand sequences and random stimulus,
// all checked against an operation-list reference model.
module tb_tiny_nn_seq;

  localparam int NI   = 4;
  localparam int NO   = 4;
  localparam int NOPS = NO * (NI + 2) + 1;
  localparam int K_CLEAR = 1, K_MAC = 2, K_WRITE = 3, K_DONE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, stall;
  logic       busy, done, clr, mac, we;
  logic [3:0] w_addr;
  logic [1:0] x_addr, out_addr;

  logic       start2, abort2, stall2;
  logic       busy2, done2, clr2, mac2, we2;
  logic [2:0] w2;
  logic [1:0] x2;
  logic [0:0] o2;

  tiny_nn_seq #(.N_IN(NI), .N_OUT(NO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .stall_i(stall),
    .busy_o(busy), .done_o(done), .acc_clr_o(clr), .mac_en_o(mac), .out_we_o(we),
    .w_addr_o(w_addr), .x_addr_o(x_addr), .out_addr_o(out_addr)
  );

  tiny_nn_seq #(.N_IN(3), .N_OUT(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .abort_i(abort2), .stall_i(stall2),
    .busy_o(busy2), .done_o(done2), .acc_clr_o(clr2), .mac_en_o(mac2), .out_we_o(we2),
    .w_addr_o(w2), .x_addr_o(x2), .out_addr_o(o2)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Reference model: the whole pass as a flat list of operations; pos walks it.
  typedef struct { int kind; int j; int k; } op_t;
  op_t ops[NOPS];
  int  pos = -1;

  int mac_cnt, done_cnt, done_c, cur_cyc;

  task automatic build_ops();
    int idx = 0;
    for (int j = 0; j < NO; j++) begin
      ops[idx] = '{K_CLEAR, j, 0}; idx++;
      for (int k = 0; k < NI; k++) begin
        ops[idx] = '{K_MAC, j, k}; idx++;
      end
      ops[idx] = '{K_WRITE, j, NI - 1}; idx++;
    end
    ops[idx] = '{K_DONE, 0, 0};
  endtask

  task automatic check_outputs(bit sl);
    int kind = (pos < 0) ? 0 : ops[pos].kind;
    chk("busy",    int'(busy), int'(pos >= 0));
    chk("done",    int'(done), int'(kind == K_DONE));
    chk("acc_clr", int'(clr),  int'(kind == K_CLEAR && !sl));
    chk("mac_en",  int'(mac),  int'(kind == K_MAC && !sl));
    chk("out_we",  int'(we),   int'(kind == K_WRITE && !sl));
    if (pos < 0) begin
      chk("idle_w_addr", int'(w_addr), 0);
      chk("idle_x_addr", int'(x_addr), 0);
      chk("idle_out_addr", int'(out_addr), 0);
    end else if (kind == K_MAC || kind == K_WRITE) begin
      chk("w_addr",   int'(w_addr),   ops[pos].j * NI + ops[pos].k);
      chk("x_addr",   int'(x_addr),   ops[pos].k);
      chk("out_addr", int'(out_addr), ops[pos].j);
    end
  endtask

  task automatic model_edge(bit st, bit ab, bit sl);
    if (pos < 0) begin
      if (st && !ab) pos = 0;
    end else if (ab) begin
      pos = -1;
    end else if (!(sl && ops[pos].kind != K_DONE)) begin
      pos++;
      if (pos == NOPS) pos = -1;
    end
  endtask

  task automatic step(bit st, bit sl, bit ab);
    start = st; stall = sl; abort = ab;
    @(negedge clk);
    check_outputs(sl);
    if (mac) mac_cnt++;
    if (done) begin
      done_cnt++;
      if (done_c < 0) done_c = cur_cyc;
    end
    @(posedge clk);
    model_edge(st, ab, sl);
    #1;
  endtask

  typedef struct {
    string name;
    int sa; int sb; int st_lo; int st_hi; int ab_c;
    int exp_done_c; int exp_dones; int exp_macs;
  } rec_t;
  rec_t recs[7];

  int q_w[$], q_x[$], q_we[$], q_dn[$];

  initial begin
    recs[0] = '{"basic",       -1, -1, -1, -1, -1, 25, 1, 16};
    recs[1] = '{"stall_mac",   -1, -1,  3,  4, -1, 27, 1, 16};
    recs[2] = '{"abort",       11, -1, -1, -1, 10, 36, 1, 23};
    recs[3] = '{"start_busy",   5, 25, -1, -1, -1, 25, 1, 16};
    recs[4] = '{"stall_write", -1, -1,  6,  8, -1, 28, 1, 16};
    recs[5] = '{"abort_idle",  -1, -1, -1, -1,  0, -1, 0,  0};
    recs[6] = '{"stall_idle",  -1, -1,  0,  0, -1, 25, 1, 16};
    build_ops();

    rst_n = 1'b0; start = 0; abort = 0; stall = 0;
    start2 = 0; abort2 = 0; stall2 = 0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_strobes", int'({clr, mac, we}), 0);
    chk("rst_addr", int'({w_addr, x_addr, out_addr}), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (recs[r]) begin
      mac_cnt = 0; done_cnt = 0; done_c = -1;
      for (int c = 0; c < 40; c++) begin
        cur_cyc = c;
        step((c == 0) || (c == recs[r].sa) || (c == recs[r].sb),
             (recs[r].st_lo >= 0) && (c >= recs[r].st_lo) && (c <= recs[r].st_hi),
             (c == recs[r].ab_c));
      end
      chk({recs[r].name, "_done_cycle"}, done_c, recs[r].exp_done_c);
      chk({recs[r].name, "_done_count"}, done_cnt, recs[r].exp_dones);
      chk({recs[r].name, "_mac_count"},  mac_cnt,  recs[r].exp_macs);
    end

    // Asynchronous reset in cycle 8 (MAC, j=1, k=0)
    for (int c = 0; c < 8; c++) step(c == 0, 1'b0, 1'b0);
    start = 0; stall = 0; abort = 0;
    @(negedge clk);
    check_outputs(1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_mac", int'(mac), 0);
    chk("async_rst_w_addr", int'(w_addr), 0);
    chk("async_rst_out_addr", int'(out_addr), 0);
    pos = -1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mac_cnt = 0; done_cnt = 0; done_c = -1;
    for (int c = 0; c < 8; c++) step(1'b0, c[0], 1'b0);
    for (int c = 0; c < 30; c++) begin
      cur_cyc = c;
      step(c == 0, 1'b0, 1'b0);
    end
    chk("after_rst_done_cycle", done_c, 25);
    chk("after_rst_mac_count", mac_cnt, 16);

    // N_IN=3, N_OUT=2 instance
    for (int c = 0; c < 15; c++) begin
      start2 = (c == 0);
      @(negedge clk);
      if (mac2) begin q_w.push_back(int'(w2)); q_x.push_back(int'(x2)); end
      if (we2) q_we.push_back(c);
      if (done2) q_dn.push_back(c);
      @(posedge clk); #1;
    end
    chk("p2_mac_count", q_w.size(), 6);
    for (int i = 0; i < 6 && i < q_w.size(); i++) begin
      chk("p2_w_addr", q_w[i], i);
      chk("p2_x_addr", q_x[i], i % 3);
    end
    chk("p2_we_count", q_we.size(), 2);
    if (q_we.size() == 2) begin
      chk("p2_we0_cycle", q_we[0], 5);
      chk("p2_we1_cycle", q_we[1], 10);
    end
    chk("p2_done_count", q_dn.size(), 1);
    if (q_dn.size() == 1) chk("p2_done_cycle", q_dn[0], 11);
    chk("p2_idle", int'(busy2), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      cur_cyc = c;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
